imem_loader: RTL
================

# imem_loader

Byte-stream program loader that fills the instruction memory through its write port before the processor runs. Accepts bytes from a host link over a valid/ready handshake, packs them big-endian into 32-bit instruction words and issues one write per word at consecutive addresses from 0. Holds the CPU via `cpu_hold` until the image is fully written, then releases it.

## Interface
- `ADDR_W`, 10, instruction memory address width (word addressed).
- `DEPTH`, 1000, number of instruction words (addresses 0..DEPTH-1).
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a load; `len` sampled with it.
- `len`  in  ADDR_W+1  number of words to load, legal 1..DEPTH.
- `in_byte`  in  8  stream data byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  instruction memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  32  write data.
- `busy`  out  1  load in progress.
- `done`  out  1  image fully written (level).
- `error`  out  1  load rejected or failed (level).
- `cpu_hold`  out  1  processor held in reset/stall while high.

## Operation
- States: IDLE, LOAD, CHECK (only with checksum), DONE, ERR.
- IDLE/DONE/ERR: `start`=1 samples `len`; if `len`=0 or `len`>DEPTH go to ERR, else clear word counter, byte counter, checksum, `done`, `error`, go to LOAD. `start` in LOAD/CHECK is ignored.
- LOAD: `in_ready`=1. Byte accepted when `in_valid`&&`in_ready`. Byte 0 of a word → bits 31:24, byte 3 → bits 7:0.
- On the 4th byte accepted: next cycle `mem_we`=1, `mem_addr`=word index, `mem_wdata`=packed word; word index increments. Byte collection continues without stall during the write cycle.
- After the `len`-th word's 4th byte: go to CHECK (checksum build) or to a final write cycle then DONE.
- DONE: `done`=1, `cpu_hold`=0 until next `start`.
- ERR: `error`=1, `cpu_hold`=1 until next `start`.
- `cpu_hold`=1 in every state except DONE. `busy`=1 in LOAD and CHECK.
- Partial image (stream stalls) waits indefinitely; only `rst_n` or completion leaves LOAD.
- Reset mid-load: all state cleared instantly, no further `mem_we`; memory contents already written are left as is.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `error`=0, `cpu_hold`=1; state IDLE.
- `start` at edge k → LOAD (or ERR) visible from cycle k+1; `in_ready` high from cycle k+1.
- 4th byte handshake in cycle n → `mem_we` high exactly in cycle n+1, registered outputs.
- Last write in cycle m → `done`=1 and `cpu_hold`=0 from cycle m+1 (never in the same cycle as a write).
- Full-rate stream: one word per 4 cycles, `len`=DEPTH finishes in 4·DEPTH+2 cycles after `start`.
- `mem_addr` wraps never: counter stops at `len`-1; `mem_addr` holds last value after the load.

## Configuration
- `IMEM_LOADER_CHECKSUM_EN` defined: after the last data byte, state CHECK accepts one more byte (`in_ready`=1) equal to the XOR of all data bytes; match → DONE the cycle after, mismatch → ERR. The final `mem_we` still occurs (cycle after last data byte); `done` never asserts before the checksum is accepted.
- Undefined: no CHECK state, no checksum byte; loader goes to DONE the cycle after the final write.

## Test plan
- Reset: `rst_n`=0 mid-simulation → all outputs at reset values immediately, `cpu_hold`=1, no `mem_we`.
- `start`, `len`=2, stream 08 00 10 00 04 22 40 00 back-to-back → `mem_we` at addr 0 data 0x08001000, addr 1 data 0x04224000, `done`=1 cycle after second write, `cpu_hold`=0.
- Same load with `in_valid` toggled every other cycle → identical writes, each `mem_we` exactly 1 cycle after the 4th accepted byte.
- `len`=0 and `len`=1001 → ERR next cycle, `error`=1, no `mem_we`; new `start` with `len`=1 recovers.
- With `IMEM_LOADER_CHECKSUM_EN`: above 8 bytes + 0x7E → DONE; + 0x7F → ERR, `cpu_hold` stays 1, both words still written.
- `start` pulsed during LOAD, and `rst_n` asserted after 5 bytes → start ignored; reset aborts with only addr 0 written.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: packs a big-endian host byte stream into 32-bit words, writes them to IMEM from address 0 and holds the CPU until the image is in.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before DONE.
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, DONE, ERR} state_t;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W-1:0] word_cnt;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic              last_taken;
    logic              len_ok;
    logic              launch;
    logic              load_acc;
    logic              last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign len_ok    = (len != '0) && (len <= DEPTH_L);
    assign launch    = start && len_ok && (state != LOAD) && (state != CHECK);
    // Acceptance is derived from state, not from in_ready, to keep the comb block loop-free.
    assign load_acc  = (state == LOAD) && !last_taken && in_valid;
    assign last_byte = load_acc && (byte_cnt == 2'd3) && ({1'b0, word_cnt} == len_q - 1'b1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        cpu_hold  = 1'b1;
        case (state)
            IDLE: begin
                if (start) state_nxt = len_ok ? LOAD : ERR;
            end
            LOAD: begin
                in_ready = !last_taken;
                busy     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (last_byte) state_nxt = CHECK;
`else
                // last_taken marks the final write cycle; DONE follows it.
                if (last_taken) state_nxt = DONE;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) state_nxt = (in_byte == csum) ? DONE : ERR;
            end
`endif
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) state_nxt = len_ok ? LOAD : ERR;
            end
            ERR: begin
                error = 1'b1;
                if (start) state_nxt = len_ok ? LOAD : ERR;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            shift      <= '0;
            last_taken <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            mem_we <= 1'b0;
            if (launch) begin
                len_q      <= len;
                word_cnt   <= '0;
                byte_cnt   <= '0;
                last_taken <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end else if (load_acc) begin
                byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                csum     <= csum ^ in_byte;
`endif
                if (byte_cnt == 2'd3) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= word_cnt;
                    mem_wdata <= {shift, in_byte};
                    if (last_byte) begin
                        last_taken <= 1'b1;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end else begin
                    shift <= {shift[15:0], in_byte};
                end
            end
        end
    end

endmodule
